// File: rtl/rtc_epoch_bcd_pkg.sv
// +----------------------------------------------------------------------------+
// | rtc_pkg: constants, FSM states and helpers shared by rtc_epoch_bcd and the  |
// | Apple II clock card. Revision: 1.0                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package rtc_pkg;

  localparam int unsigned SECS_PER_DAY  = 86400;
  localparam int unsigned SECS_PER_HOUR = 3600;
  localparam int unsigned SECS_PER_MIN  = 60;
  localparam int unsigned EPOCH_YEAR    = 1970;
  localparam int unsigned EPOCH_DOW     = 4;

  // Packed RTC bus layout, shared with the clock card
  localparam int unsigned RTC_W        = 65;
  localparam int unsigned RTC_SEC_LSB  = 0;
  localparam int unsigned RTC_MIN_LSB  = 8;
  localparam int unsigned RTC_HOUR_LSB = 16;
  localparam int unsigned RTC_DAY_LSB  = 24;
  localparam int unsigned RTC_MON_LSB  = 32;
  localparam int unsigned RTC_YEAR_LSB = 40;
  localparam int unsigned RTC_DOW_LSB  = 48;
  localparam int unsigned RTC_FLAG_BIT = 64;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DIV_DAY = 4'd1,
    S_HOUR    = 4'd2,
    S_MIN     = 4'd3,
    S_DOW     = 4'd4,
    S_YEAR    = 4'd5,
    S_MONTH   = 4'd6,
    S_PUBLISH = 4'd7
  } rtc_state_t;

  // Exact for the 1970..2106 span covered by a 32-bit epoch
  function automatic logic is_leap(input logic [11:0] year);
    return (year[1:0] == 2'b00) && (year != 12'd2100);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                     return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  // Keeps only the two low decimal digits, so years 2100+ wrap to 00..06
  function automatic logic [7:0] bin2bcd7(input logic [6:0] value);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = (value / 7'd10) % 7'd10;
    ones = value % 7'd10;
    return {4'(tens), 4'(ones)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_restoring_div.sv
// +----------------------------------------------------------------------------+
// | rtc_restoring_div: serial restoring divider, one quotient bit per cycle,    |
// | start/done handshake. Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module rtc_restoring_div #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DWIDTH = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WIDTH-1:0]  i_dividend,
  input  logic [DWIDTH-1:0] i_divisor,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_quotient,
  output logic [DWIDTH-1:0] o_remainder
);

  localparam int unsigned c_cnt_w = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_quo;
  logic [DWIDTH-1:0]  r_rem;
  logic [DWIDTH-1:0]  r_div;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [DWIDTH:0]    w_trial;
  logic               w_ge;
  logic [DWIDTH-1:0]  w_rem_next;

  // Quotient bits shift in from the right as dividend bits shift out the top
  assign w_trial    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_rem_next = w_ge ? DWIDTH'(w_trial - {1'b0, r_div}) : DWIDTH'(w_trial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_cnt  <= c_cnt_w'(WIDTH);
        r_busy <= 1'b1;
      end else if (i_abort) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - c_cnt_w'(1);
        if (r_cnt == c_cnt_w'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/rtc_epoch_bcd.sv
// +----------------------------------------------------------------------------+
// | rtc_epoch_bcd: Unix-epoch seconds to packed BCD RTC bus for the clock card. |
// | Optional free-running timekeeping: define RTC_FREERUN_EN. Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module rtc_epoch_bcd
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 14318180
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic [32:0] TIMESTAMP,
  output logic [64:0] RTC,
  output logic        BUSY,
  output logic        VALID
);

  rtc_state_t  r_state;
  logic [1:0]  r_sync;
  logic        r_sync_q;
  logic [31:0] r_secs;
  logic [15:0] r_days;
  logic [16:0] r_sod;
  logic [4:0]  r_hour;
  logic [5:0]  r_min;
  logic [5:0]  r_sec;
  logic [2:0]  r_dow;
  logic [11:0] r_year;
  logic [3:0]  r_month;
  logic [4:0]  r_mday;
  logic        r_day_start;
  logic        r_dow_start;
  logic        r_dow_abort;
  logic        r_pub_d;

  logic        w_host_upd;
  logic        w_day_done;
  logic [31:0] w_day_quo;
  logic [16:0] w_day_rem;
  logic        w_dow_done;
  logic [15:0] w_dow_quo;
  logic [2:0]  w_dow_rem;
  logic [15:0] w_dow_dividend;
  logic [15:0] w_year_len;
  logic [4:0]  w_mon_len;
  logic [11:0] w_yy;
  logic        w_unused_bits;

`ifdef RTC_FREERUN_EN
  localparam int unsigned c_presc_w = $clog2(CLK_FREQ);
  logic [c_presc_w-1:0] r_presc;
  logic                 r_pending;
  logic                 w_tick;
  assign w_tick = (r_presc == c_presc_w'(CLK_FREQ - 1));
`endif

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync   <= 2'b00;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], TIMESTAMP[32]};
      r_sync_q <= r_sync[1];
    end
  end

  assign w_host_upd     = r_sync[1] ^ r_sync_q;
  assign w_dow_dividend = r_days + 16'(EPOCH_DOW);
  assign w_year_len     = is_leap(r_year) ? 16'd366 : 16'd365;
  assign w_mon_len      = month_len(r_month, is_leap(r_year));
  assign w_yy           = (r_year >= 12'd2000) ? (r_year - 12'd2000) : (r_year - 12'd1900);
  assign w_unused_bits  = ^{w_day_quo[31:16], w_dow_quo, (CLK_FREQ != 0)};

  rtc_restoring_div #(
    .WIDTH  (32),
    .DWIDTH (17)
  ) u_div_day (
    .clk         (CLK_14M),
    .rst_n       (RESET_N),
    .i_start     (r_day_start),
    .i_abort     (1'b0),
    .i_dividend  (r_secs),
    .i_divisor   (17'(SECS_PER_DAY)),
    .o_done      (w_day_done),
    .o_quotient  (w_day_quo),
    .o_remainder (w_day_rem)
  );

  rtc_restoring_div #(
    .WIDTH  (16),
    .DWIDTH (3)
  ) u_div_dow (
    .clk         (CLK_14M),
    .rst_n       (RESET_N),
    .i_start     (r_dow_start),
    .i_abort     (r_dow_abort),
    .i_dividend  (w_dow_dividend),
    .i_divisor   (3'd7),
    .o_done      (w_dow_done),
    .o_quotient  (w_dow_quo),
    .o_remainder (w_dow_rem)
  );

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_secs      <= '0;
      r_days      <= '0;
      r_sod       <= '0;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_dow       <= '0;
      r_year      <= '0;
      r_month     <= '0;
      r_mday      <= '0;
      r_day_start <= 1'b0;
      r_dow_start <= 1'b0;
      r_dow_abort <= 1'b0;
      r_pub_d     <= 1'b0;
      RTC         <= '0;
      BUSY        <= 1'b0;
      VALID       <= 1'b0;
`ifdef RTC_FREERUN_EN
      r_presc     <= '0;
      r_pending   <= 1'b0;
`endif
    end else begin
      r_day_start <= 1'b0;
      r_dow_start <= 1'b0;
      r_dow_abort <= 1'b0;
      r_pub_d     <= 1'b0;

      // Flag toggles one cycle after the fields load so the card never sees a torn value
      if (r_pub_d) begin
        RTC[RTC_FLAG_BIT] <= ~RTC[RTC_FLAG_BIT];
        VALID             <= 1'b1;
      end

`ifdef RTC_FREERUN_EN
      if (w_host_upd || w_tick) r_presc <= '0;
      else                      r_presc <= r_presc + c_presc_w'(1);
`endif

      if (w_host_upd) begin
        r_secs      <= TIMESTAMP[31:0];
        r_state     <= S_DIV_DAY;
        BUSY        <= 1'b1;
        r_day_start <= 1'b1;
        r_dow_abort <= 1'b1;
`ifdef RTC_FREERUN_EN
        r_pending   <= 1'b0;
`endif
      end else begin
`ifdef RTC_FREERUN_EN
        if (w_tick) begin
          r_secs <= r_secs + 32'd1;
          if (r_state != S_IDLE) r_pending <= 1'b1;
        end
`endif
        case (r_state)
          S_IDLE: begin
            BUSY <= 1'b0;
`ifdef RTC_FREERUN_EN
            if (w_tick || r_pending) begin
              r_pending   <= 1'b0;
              r_state     <= S_DIV_DAY;
              BUSY        <= 1'b1;
              r_day_start <= 1'b1;
            end
`endif
          end
          S_DIV_DAY: begin
            // A done seen while the start pulse is still pending belongs to an aborted run
            if (w_day_done && !r_day_start) begin
              r_days  <= w_day_quo[15:0];
              r_sod   <= w_day_rem;
              r_hour  <= '0;
              r_state <= S_HOUR;
            end
          end
          S_HOUR: begin
            if (r_sod >= 17'(SECS_PER_HOUR)) begin
              r_sod  <= r_sod - 17'(SECS_PER_HOUR);
              r_hour <= r_hour + 5'd1;
            end else begin
              r_min   <= '0;
              r_state <= S_MIN;
            end
          end
          S_MIN: begin
            if (r_sod >= 17'(SECS_PER_MIN)) begin
              r_sod <= r_sod - 17'(SECS_PER_MIN);
              r_min <= r_min + 6'd1;
            end else begin
              r_sec       <= r_sod[5:0];
              r_dow_start <= 1'b1;
              r_state     <= S_DOW;
            end
          end
          S_DOW: begin
            if (w_dow_done && !r_dow_start) begin
              r_dow   <= w_dow_rem;
              r_year  <= 12'(EPOCH_YEAR);
              r_state <= S_YEAR;
            end
          end
          S_YEAR: begin
            if (r_days >= w_year_len) begin
              r_days <= r_days - w_year_len;
              r_year <= r_year + 12'd1;
            end else begin
              r_month <= 4'd1;
              r_state <= S_MONTH;
            end
          end
          S_MONTH: begin
            if (r_days >= {11'b0, w_mon_len}) begin
              r_days  <= r_days - {11'b0, w_mon_len};
              r_month <= r_month + 4'd1;
            end else begin
              r_mday  <= 5'(r_days + 16'd1);
              r_state <= S_PUBLISH;
            end
          end
          S_PUBLISH: begin
            RTC[RTC_SEC_LSB  +: 7] <= 7'(bin2bcd7({1'b0, r_sec}));
            RTC[RTC_MIN_LSB  +: 7] <= 7'(bin2bcd7({1'b0, r_min}));
            RTC[RTC_HOUR_LSB +: 6] <= 6'(bin2bcd7({2'b0, r_hour}));
            RTC[RTC_DAY_LSB  +: 6] <= 6'(bin2bcd7({2'b0, r_mday}));
            RTC[RTC_MON_LSB  +: 5] <= 5'(bin2bcd7({3'b0, r_month}));
            RTC[RTC_YEAR_LSB +: 8] <= bin2bcd7(7'(w_yy));
            RTC[RTC_DOW_LSB  +: 3] <= r_dow;
            r_pub_d <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_epoch_bcd.sv
// Scoreboard bench for rtc_epoch_bcd: a calendar model predicts each publish,
// a monitor compares whenever the update flag RTC[64] toggles.
`default_nettype none

module tb_rtc_epoch_bcd;

`ifdef RTC_FREERUN_EN
  localparam int unsigned TB_CLK_FREQ = 100;
`else
  localparam int unsigned TB_CLK_FREQ = 14318180;
`endif
  localparam int unsigned MAX_LAT = 303;

  logic        CLK_14M   = 1'b0;
  logic        RESET_N   = 1'b0;
  logic [32:0] TIMESTAMP = '0;
  logic [64:0] RTC;
  logic        BUSY;
  logic        VALID;

  rtc_epoch_bcd #(
    .CLK_FREQ (TB_CLK_FREQ)
  ) dut (
    .CLK_14M   (CLK_14M),
    .RESET_N   (RESET_N),
    .TIMESTAMP (TIMESTAMP),
    .RTC       (RTC),
    .BUSY      (BUSY),
    .VALID     (VALID)
  );

  always #5 CLK_14M = ~CLK_14M;

  int unsigned cyc = 0;
  always @(posedge CLK_14M) cyc++;

  typedef struct {
    logic [64:0] rtc;
    int unsigned t_issue;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pub    = 0;
  logic exp_flag = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- calendar reference model ----------------
  function automatic bit leap_year(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int days_in_month(input int y, input int m);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && leap_year(y)) return 29;
    return tbl[m-1];
  endfunction

  function automatic logic [7:0] bcd(input int v);
    int w;
    w = v % 100;
    return 8'((w / 10) * 16 + (w % 10));
  endfunction

  function automatic logic [64:0] expected_rtc(input logic [31:0] ts, input logic flag);
    longint t;
    int days_total, days, sod, y, m;
    logic [64:0] r;
    t          = longint'({32'b0, ts});
    days_total = int'(t / 86400);
    sod        = int'(t % 86400);
    days       = days_total;
    y = 1970;
    while (days >= (leap_year(y) ? 366 : 365)) begin
      days -= leap_year(y) ? 366 : 365;
      y++;
    end
    m = 1;
    while (days >= days_in_month(y, m)) begin
      days -= days_in_month(y, m);
      m++;
    end
    r        = '0;
    r[7:0]   = bcd(sod % 60);
    r[15:8]  = bcd((sod / 60) % 60);
    r[23:16] = bcd(sod / 3600);
    r[31:24] = bcd(days + 1);
    r[39:32] = bcd(m);
    r[47:40] = bcd(y % 100);
    r[50:48] = 3'((days_total + 4) % 7);
    r[64]    = flag;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push_expect(input logic [31:0] secs);
    exp_t e;
    exp_flag  = ~exp_flag;
    e.rtc     = expected_rtc(secs, exp_flag);
    e.t_issue = cyc;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic host_update(input logic [31:0] v, input bit will_publish);
    @(negedge CLK_14M);
    TIMESTAMP = {~TIMESTAMP[32], v};
    if (will_publish) push_expect(v);
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    while (sb_q.size() != 0 && i < bound) begin
      @(negedge CLK_14M);
      i++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL publish_timeout pending=%0d after %0d cycles", sb_q.size(), bound);
      sb_q.delete();
    end
  endtask

  task automatic convert(input logic [31:0] v);
    host_update(v, 1'b1);
    repeat (10) @(negedge CLK_14M);
    check("busy_during_conv", {64'b0, BUSY}, 65'd1);
    wait_drain(400);
  endtask

  // ---------------- monitor ----------------
  logic        prev_flag   = 1'b0;
  logic [63:0] prev_fields = '0;

  always @(negedge CLK_14M) begin
    exp_t e;
    int unsigned lat;
    if (!RESET_N) begin
      prev_flag   = 1'b0;
      prev_fields = '0;
    end else begin
      if (RTC[64] != prev_flag) begin
        n_pub++;
        check("fields_stable_before_toggle", {1'b0, RTC[63:0]}, {1'b0, prev_fields});
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_publish actual=0x%0h required=no publish", RTC);
        end else begin
          e = sb_q.pop_front();
          check("rtc_value", RTC, e.rtc);
          check("valid_at_publish", {64'b0, VALID}, 65'd1);
          lat = cyc - e.t_issue;
          n_checks++;
          if (lat > MAX_LAT) begin
            n_fail++;
            $display("FAIL latency actual=%0d cycles required<=%0d", lat, MAX_LAT);
          end
        end
      end
      prev_flag   = RTC[64];
      prev_fields = RTC[63:0];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] directed[6] = '{32'd0, 32'd951782400, 32'd4107542399,
                                  32'd4107542400, 32'hFFFF_FFFF, 32'd1234567890};
    RESET_N   = 1'b0;
    TIMESTAMP = '0;
    repeat (5) @(negedge CLK_14M);
    check("reset_rtc",   RTC, 65'd0);
    check("reset_busy",  {64'b0, BUSY}, 65'd0);
    check("reset_valid", {64'b0, VALID}, 65'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_14M);

`ifndef RTC_FREERUN_EN
    foreach (directed[i]) convert(directed[i]);
    for (int i = 0; i < 12; i++) convert($urandom());

    // Second update lands mid-conversion: only the newest value may publish
    host_update(32'd1234567890, 1'b0);
    repeat (50) @(negedge CLK_14M);
    host_update(32'd0, 1'b1);
    wait_drain(400);
    repeat (350) @(negedge CLK_14M);

    // Reset in the middle of a conversion
    host_update(32'd86400 * 1000 + 32'd86399, 1'b0);
    repeat (100) @(negedge CLK_14M);
    check("busy_before_reset", {64'b0, BUSY}, 65'd1);
    RESET_N   = 1'b0;
    TIMESTAMP = '0;
    exp_flag  = 1'b0;
    repeat (2) @(negedge CLK_14M);
    check("midreset_rtc",   RTC, 65'd0);
    check("midreset_busy",  {64'b0, BUSY}, 65'd0);
    check("midreset_valid", {64'b0, VALID}, 65'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_14M);
    convert(32'd951782400);
    convert($urandom());
    repeat (20) @(negedge CLK_14M);
`else
    convert(32'd59);
    // The prescaler restarted at the host update; next wrap publishes 00:01:00
    push_expect(32'd60);
    wait_drain(400);
    check("freerun_toggle_total", 65'(n_pub), 65'd2);
`endif

    check("publish_count", 65'(n_pub), 65'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
